// File: rtl/uart_pkg.sv
// Shared types and widths for the UART baud-rate controller.
package uart_pkg;

  localparam int SyncEdges = 8;
  localparam int DividerW  = 16;
  localparam int TotalW    = 20;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    MEASURE,
    APPLY,
    ERR
  } autobaud_state_t;

endpackage

// File: rtl/uart_edge_detect.sv
// Registers the synchronized RX line and flags rising/falling transitions.
module uart_edge_detect
  import uart_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  output logic o_rise,
  output logic o_fall
);

  logic rx_q;

  // Idle line is high, so a reset value of 1 avoids a false start edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_q <= 1'b1;
    end else begin
      rx_q <= i_rx;
    end
  end

  assign o_fall = rx_q & ~i_rx;
  assign o_rise = ~rx_q & i_rx;

endmodule

// File: rtl/uart_autobaud.sv
// Owns the prescaler divider: measures a 0x55 sync character or takes software
// writes, and only changes the divider while the UART datapath is idle.
module uart_autobaud
  import uart_pkg::*;
#(
  parameter int unsigned InitialDivider = 16,
  parameter int unsigned MinDivider     = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_rx,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic                i_busy,
  input  logic                i_cfg_we,
  input  logic [DividerW-1:0] i_cfg_scaler,
  output logic [DividerW-1:0] o_scaler,
  output logic                o_active,
  output logic                o_done,
  output logic                o_err
);

  localparam int EdgeW = $clog2(SyncEdges);

  autobaud_state_t     state_reg, state_next;
  logic [DividerW-1:0] seg_cnt_reg, seg_cnt_next;
  logic [TotalW-1:0]   total_reg, total_next;
  logic [EdgeW-1:0]    edge_n_reg, edge_n_next;
  logic [DividerW-1:0] l1_reg, l1_next;
  logic [DividerW-1:0] div_reg, div_next;
  logic [DividerW-1:0] scaler_reg, scaler_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;
  logic                active_reg, active_next;

  logic                rx_rise, rx_fall, rx_edge;
  logic [DividerW-1:0] tol_lo;
  logic [DividerW:0]   tol_hi;
  logic                in_tol;
  logic [DividerW-1:0] d_calc;

  uart_edge_detect u_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_rx    (i_rx),
    .o_rise  (rx_rise),
    .o_fall  (rx_fall)
  );

  assign rx_edge = rx_rise | rx_fall;

  // Each segment must lie within [L1/2, 1.5*L1]; the upper bound needs a carry bit.
  assign tol_lo = l1_reg >> 1;
  assign tol_hi = {1'b0, l1_reg} + {2'b00, l1_reg[DividerW-1:1]};
  assign in_tol = (seg_cnt_reg >= tol_lo) && ({1'b0, seg_cnt_reg} <= tol_hi);

  // Eight bit periods summed, rounded to nearest on the divide by 8.
  assign d_calc = DividerW'((total_reg + TotalW'(4)) >> 3);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      seg_cnt_reg <= '0;
      total_reg   <= '0;
      edge_n_reg  <= '0;
      l1_reg      <= '0;
      div_reg     <= '0;
      scaler_reg  <= DividerW'(InitialDivider);
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      active_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      seg_cnt_reg <= seg_cnt_next;
      total_reg   <= total_next;
      edge_n_reg  <= edge_n_next;
      l1_reg      <= l1_next;
      div_reg     <= div_next;
      scaler_reg  <= scaler_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      active_reg  <= active_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    seg_cnt_next = seg_cnt_reg;
    total_next   = total_reg;
    edge_n_next  = edge_n_reg;
    l1_next      = l1_reg;
    div_next     = div_reg;
    scaler_next  = scaler_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (i_cfg_we && (i_cfg_scaler != '0)) begin
          scaler_next = i_cfg_scaler;
        end
        if (i_start) begin
          state_next = ARM;
        end
      end

      ARM: begin
        if (i_abort) begin
          state_next = IDLE;
        end else if (rx_fall) begin
          seg_cnt_next = DividerW'(1);
          total_next   = TotalW'(1);
          edge_n_next  = '0;
          state_next   = MEASURE;
        end
      end

      MEASURE: begin
        if (i_abort) begin
          state_next = IDLE;
        end else if (rx_edge) begin
          seg_cnt_next = DividerW'(1);
          total_next   = total_reg + 1'b1;
          edge_n_next  = edge_n_reg + 1'b1;
          if (edge_n_reg == '0) begin
            l1_next = seg_cnt_reg;
          end else if (!in_tol) begin
            state_next = ERR;
            err_next   = 1'b1;
          end else if (edge_n_reg == EdgeW'(SyncEdges - 1)) begin
            if (d_calc < DividerW'(MinDivider)) begin
              state_next = ERR;
              err_next   = 1'b1;
            end else if (i_busy) begin
              div_next   = d_calc;
              state_next = APPLY;
            end else begin
              // Datapath already idle: skip APPLY so the divider lands next cycle.
              div_next    = d_calc;
              scaler_next = d_calc;
              done_next   = 1'b1;
              state_next  = IDLE;
            end
          end
        end else if (seg_cnt_reg == '1) begin
          state_next = ERR;
          err_next   = 1'b1;
        end else begin
          seg_cnt_next = seg_cnt_reg + 1'b1;
          total_next   = total_reg + 1'b1;
        end
      end

      APPLY: begin
        if (i_abort) begin
          state_next = IDLE;
        end else if (!i_busy) begin
          scaler_next = div_reg;
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end

      ERR: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    active_next = (state_next == ARM) || (state_next == MEASURE) || (state_next == APPLY);
  end

  assign o_scaler = scaler_reg;
  assign o_active = active_reg;
  assign o_done   = done_reg;
  assign o_err    = err_reg;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: software writes, sync measurements,
// deferred apply, error cases and abort.
module tb_uart_autobaud;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic        start;
  logic        abort;
  logic        busy;
  logic        cfg_we;
  logic [15:0] cfg_scaler;
  logic [15:0] scaler;
  logic        active;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int err_seen = 0;
  int done_mark;
  int err_mark;
  int segs [8];

  uart_autobaud dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx         (rx),
    .i_start      (start),
    .i_abort      (abort),
    .i_busy       (busy),
    .i_cfg_we     (cfg_we),
    .i_cfg_scaler (cfg_scaler),
    .o_scaler     (scaler),
    .o_active     (active),
    .o_done       (done),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (done) done_seen++;
    if (err) err_seen++;
  endtask

  task automatic hold_rx(input logic v, input int n);
    rx = v;
    repeat (n) tick();
  endtask

  task automatic set_segs(input int n);
    for (int i = 0; i < 8; i++) segs[i] = n;
  endtask

  // Segment i is the start bit (i=0) or data bit i-1 of 0x55: even low, odd high.
  task automatic run_segs(input int first, input int last);
    for (int i = first; i <= last; i++) hold_rx((i % 2) == 1, segs[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx = 1'b1; start = 1'b0; abort = 1'b0; busy = 1'b0;
    cfg_we = 1'b0; cfg_scaler = '0;
    repeat (3) tick();
    check("reset_scaler", 32'(scaler), 32'd16);
    check("reset_active", 32'(active), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Software writes: 217 applies, 0 is ignored.
    cfg_we = 1'b1; cfg_scaler = 16'd217;
    tick();
    check("sw_write_217", 32'(scaler), 32'd217);
    cfg_scaler = 16'd0;
    tick();
    cfg_we = 1'b0;
    check("sw_write_zero", 32'(scaler), 32'd217);

    // 100 cycles/bit, busy low: divider lands one cycle after edge 8.
    pulse_start();
    check("arm_active", 32'(active), 32'd1);
    set_segs(100);
    run_segs(0, 7);
    check("m100_pre_done", 32'(done), 32'd0);
    check("m100_pre_scaler", 32'(scaler), 32'd217);
    rx = 1'b0;
    tick();
    check("m100_done", 32'(done), 32'd1);
    check("m100_scaler", 32'(scaler), 32'd100);
    check("m100_active", 32'(active), 32'd0);
    tick();
    check("m100_done_pulse", 32'(done), 32'd0);
    hold_rx(1'b0, 98);
    hold_rx(1'b1, 200);

    // Alternating 100/101, T = 804 -> 101.
    pulse_start();
    for (int i = 0; i < 8; i++) segs[i] = (i % 2 == 0) ? 100 : 101;
    run_segs(0, 7);
    rx = 1'b0;
    tick();
    check("t804_done", 32'(done), 32'd1);
    check("t804_scaler", 32'(scaler), 32'd101);
    hold_rx(1'b0, 99);
    hold_rx(1'b1, 200);

    // T = 803 -> 100.
    pulse_start();
    segs[7] = 100;
    run_segs(0, 7);
    rx = 1'b0;
    tick();
    check("t803_scaler", 32'(scaler), 32'd100);
    hold_rx(1'b0, 99);
    hold_rx(1'b1, 200);

    // 50 cycles/bit with busy held 300 cycles after edge 8.
    busy = 1'b1;
    pulse_start();
    set_segs(50);
    run_segs(0, 7);
    rx = 1'b0;
    done_mark = done_seen;
    tick();
    check("busy_edge_scaler", 32'(scaler), 32'd100);
    check("busy_edge_active", 32'(active), 32'd1);
    for (int i = 1; i < 300; i++) begin
      rx = (i < 50) ? 1'b0 : 1'b1;
      tick();
    end
    check("busy_hold_no_done", 32'(done_seen - done_mark), 32'd0);
    check("busy_hold_scaler", 32'(scaler), 32'd100);
    busy = 1'b0;
    tick();
    check("busy_release_done", 32'(done), 32'd1);
    check("busy_release_scaler", 32'(scaler), 32'd50);
    check("busy_release_active", 32'(active), 32'd0);
    hold_rx(1'b1, 20);

    // Glitch: L1 = 100, then a 30-cycle segment.
    pulse_start();
    hold_rx(1'b0, 100);
    hold_rx(1'b1, 30);
    rx = 1'b0;
    tick();
    check("glitch_err", 32'(err), 32'd1);
    check("glitch_active", 32'(active), 32'd0);
    check("glitch_scaler", 32'(scaler), 32'd50);
    tick();
    check("glitch_err_pulse", 32'(err), 32'd0);
    hold_rx(1'b0, 70);
    hold_rx(1'b1, 200);

    // 3 cycles/bit gives D = 3, below the minimum.
    pulse_start();
    set_segs(3);
    run_segs(0, 7);
    rx = 1'b0;
    tick();
    check("min_div_err", 32'(err), 32'd1);
    check("min_div_scaler", 32'(scaler), 32'd50);
    hold_rx(1'b0, 2);
    hold_rx(1'b1, 20);

    // Software write during MEASURE is ignored; abort together with edge 5.
    done_mark = done_seen;
    err_mark = err_seen;
    pulse_start();
    set_segs(100);
    run_segs(0, 2);
    cfg_we = 1'b1; cfg_scaler = 16'd999; rx = 1'b1;
    tick();
    cfg_we = 1'b0;
    check("cfg_in_measure", 32'(scaler), 32'd50);
    hold_rx(1'b1, 99);
    run_segs(4, 4);
    rx = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_e5_active", 32'(active), 32'd0);
    run_segs(5, 7);
    hold_rx(1'b0, 100);
    hold_rx(1'b1, 100);
    check("abort_e5_no_done", 32'(done_seen - done_mark), 32'd0);
    check("abort_e5_no_err", 32'(err_seen - err_mark), 32'd0);
    check("abort_e5_scaler", 32'(scaler), 32'd50);

    // Abort in APPLY wins over a same-cycle busy release.
    busy = 1'b1;
    pulse_start();
    run_segs(0, 7);
    rx = 1'b0;
    tick();
    check("apply_active", 32'(active), 32'd1);
    abort = 1'b1; busy = 1'b0;
    tick();
    abort = 1'b0;
    check("abort_apply_active", 32'(active), 32'd0);
    hold_rx(1'b0, 98);
    hold_rx(1'b1, 100);
    check("abort_apply_no_done", 32'(done_seen - done_mark), 32'd0);
    check("abort_apply_scaler", 32'(scaler), 32'd50);

    // Timeout: line held low after the start edge.
    pulse_start();
    hold_rx(1'b0, 65535);
    check("timeout_pre_err", 32'(err), 32'd0);
    check("timeout_pre_active", 32'(active), 32'd1);
    tick();
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_scaler", 32'(scaler), 32'd50);
    hold_rx(1'b1, 10);

    // Reset restores the initial divider.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rereset_scaler", 32'(scaler), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
